// File: rtl/score_digit_ctrl.sv
// Binary score to four BCD digit codes, using sequential double-dabble and optional leading-zero blanking.
// Latency: WIDTH+1 cycles from the load edge to valid digits; outputs update atomically with a one-cycle done pulse.
// Backpressure: load is honoured only while busy=0; a load during a conversion is dropped, not queued.
module score_digit_ctrl #(
    parameter int         WIDTH      = 14,
    parameter logic [3:0] BLANK_CODE = 4'd10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] score,
    input  logic             load,
    input  logic             blank_lz,
    output logic             busy,
    output logic             done,
    output logic             sat,
    output logic [3:0]       digitL,
    output logic [3:0]       digitML,
    output logic [3:0]       digitMR,
    output logic [3:0]       digitR
);

    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

    localparam int               CW        = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAX_SCORE = WIDTH'(9999);
    localparam logic [CW-1:0]    CNT_INIT  = CW'(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] bin;
    logic [15:0]      bcd;
    logic [15:0]      bcd_adj;
    logic [CW-1:0]    cnt;
    logic             sat_n;
    logic             blz;
    logic             over;
    logic             bl3;
    logic             bl2;
    logic             bl1;

    // Scores above 9999 are clamped so the four-nibble result always stays decimal.
    assign over = (score > MAX_SCORE);
    assign busy = (state != IDLE);

    // Add-3 correction on every nibble that would overflow past 9 when doubled.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking chains from the left; an internal zero breaks the chain.
    always_comb begin
        bl3 = blz && (bcd[15:12] == 4'd0);
        bl2 = bl3 && (bcd[11:8] == 4'd0);
        bl1 = bl2 && (bcd[7:4] == 4'd0);
    end

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: WIDTH shift cycles, then one formatting cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nxt = FORMAT;
            FORMAT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath and registered display outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bin     <= '0;
            bcd     <= '0;
            cnt     <= '0;
            sat_n   <= 1'b0;
            blz     <= 1'b0;
            done    <= 1'b0;
            sat     <= 1'b0;
            digitL  <= BLANK_CODE;
            digitML <= BLANK_CODE;
            digitMR <= BLANK_CODE;
            digitR  <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        bin   <= over ? MAX_SCORE : score;
                        sat_n <= over;
                        blz   <= blank_lz;
                        bcd   <= '0;
                        cnt   <= CNT_INIT;
                    end
                end
                SHIFT: begin
                    bcd <= {bcd_adj[14:0], bin[WIDTH-1]};
                    bin <= {bin[WIDTH-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                end
                FORMAT: begin
                    digitL  <= bl3 ? BLANK_CODE : bcd[15:12];
                    digitML <= bl2 ? BLANK_CODE : bcd[11:8];
                    digitMR <= bl1 ? BLANK_CODE : bcd[7:4];
                    digitR  <= bcd[3:0];
                    sat     <= sat_n;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_digit_ctrl.sv
// Testbench for score_digit_ctrl: directed vector table plus handshake and reset sequences.
// Latency under test: WIDTH+1 cycles from the load edge to done.
// Backpressure under test: loads during busy are dropped; a held load restarts on the done cycle.
module tb_score_digit_ctrl;

    logic        clk;
    logic        clr;
    logic [13:0] score;
    logic        load;
    logic        blank_lz;
    logic        busy;
    logic        done;
    logic        sat;
    logic [3:0]  digitL;
    logic [3:0]  digitML;
    logic [3:0]  digitMR;
    logic [3:0]  digitR;
    logic [15:0] digits;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [13:0] score;
        logic        blz;
        logic [15:0] exp_dig;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[13];

    score_digit_ctrl #(.WIDTH(14), .BLANK_CODE(4'd10)) dut (
        .clk      (clk),
        .clr      (clr),
        .score    (score),
        .load     (load),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .sat      (sat),
        .digitL   (digitL),
        .digitML  (digitML),
        .digitMR  (digitMR),
        .digitR   (digitR)
    );

    assign digits = {digitL, digitML, digitMR, digitR};

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits on falling edges until done, checking the current edge first; k = edges waited, -1 on timeout.
    task automatic wait_done(output int k);
        k = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                k = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One-cycle load pulse, then the inputs are scrambled to show they are not re-sampled.
    // k is the index of the rising edge (E0 = load) after which done was seen.
    task automatic run_conv(input logic [13:0] s, input logic b, output int busy_cnt, output int k);
        @(negedge clk);
        score    = s;
        blank_lz = b;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        score    = ~s;
        blank_lz = ~b;
        busy_cnt = 0;
        k        = -1;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                k = i - 1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int bc;
        int k;
        int k2;
        int seen;

        tests_run    = 0;
        tests_failed = 0;
        clk      = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        score    = '0;
        blank_lz = 1'b0;

        vecs[0]  = '{14'd1234,  1'b1, 16'h1234, 1'b0};
        vecs[1]  = '{14'd7,     1'b1, 16'hAAA7, 1'b0};
        vecs[2]  = '{14'd0,     1'b1, 16'hAAA0, 1'b0};
        vecs[3]  = '{14'd1005,  1'b1, 16'h1005, 1'b0};
        vecs[4]  = '{14'd42,    1'b0, 16'h0042, 1'b0};
        vecs[5]  = '{14'd12000, 1'b1, 16'h9999, 1'b1};
        vecs[6]  = '{14'd9999,  1'b1, 16'h9999, 1'b0};
        vecs[7]  = '{14'd0,     1'b0, 16'h0000, 1'b0};
        vecs[8]  = '{14'd16383, 1'b0, 16'h9999, 1'b1};
        vecs[9]  = '{14'd100,   1'b1, 16'hA100, 1'b0};
        vecs[10] = '{14'd30,    1'b1, 16'hAA30, 1'b0};
        vecs[11] = '{14'd10000, 1'b1, 16'h9999, 1'b1};
        vecs[12] = '{14'd9,     1'b0, 16'h0009, 1'b0};

        // Asynchronous reset, asserted between clock edges.
        #2 clr = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sat", sat, 0);
        check("rst_digits", digits, 16'hAAA0);
        @(negedge clk);
        clr = 1'b0;

        // Vector table.
        for (int v = 0; v < 13; v++) begin
            run_conv(vecs[v].score, vecs[v].blz, bc, k);
            check($sformatf("v%0d_busy_cycles", v), bc, 15);
            check($sformatf("v%0d_done_edge", v), k, 15);
            check($sformatf("v%0d_digits", v), digits, vecs[v].exp_dig);
            check($sformatf("v%0d_sat", v), sat, vecs[v].exp_sat);
            check($sformatf("v%0d_busy_at_done", v), busy, 0);
            @(negedge clk);
            check($sformatf("v%0d_done_width", v), done, 0);
            check($sformatf("v%0d_hold", v), digits, vecs[v].exp_dig);
        end

        // Load during SHIFT is dropped.
        @(negedge clk);
        score = 14'd55; blank_lz = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        score = 14'd88; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_done(k);
        check("ign_done_edge", k, 10);
        check("ign_digits", digits, 16'hAA55);
        repeat (3) @(negedge clk);
        check("ign_not_queued", busy, 0);
        check("ign_hold", digits, 16'hAA55);

        // Held load: second conversion starts on the done cycle, period WIDTH+2.
        @(negedge clk);
        score = 14'd88; blank_lz = 1'b1; load = 1'b1;
        wait_done(k);
        check("hold_first_done", k, 16);
        check("hold_first_digits", digits, 16'hAA88);
        check("hold_busy_on_done", busy, 0);
        @(negedge clk);
        check("hold_restart_busy", busy, 1);
        check("hold_restart_done_low", done, 0);
        wait_done(k2);
        check("hold_period", k2, 15);
        load = 1'b0;
        check("hold_second_digits", digits, 16'hAA88);
        @(negedge clk);
        check("hold_after_digits", digits, 16'hAA88);
        check("hold_no_third", busy, 0);

        // Reset while idle clears a saturated result.
        run_conv(14'd12000, 1'b1, bc, k);
        check("pre_rst_sat", sat, 1);
        @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check("idle_rst_sat", sat, 0);
        check("idle_rst_digits", digits, 16'hAAA0);
        @(negedge clk);
        clr = 1'b0;

        // Reset in the middle of SHIFT discards the conversion.
        @(negedge clk);
        score = 14'd4321; blank_lz = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sat", sat, 0);
        check("mid_rst_digits", digits, 16'hAAA0);
        @(negedge clk);
        clr = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("mid_rst_no_done", seen, 0);
        check("mid_rst_digits_hold", digits, 16'hAAA0);
        run_conv(14'd9, 1'b1, bc, k);
        check("post_rst_done_edge", k, 15);
        check("post_rst_digits", digits, 16'hAAA9);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
